// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: commit-stage exception/interrupt prioritiser that drives CP0 ex_* strobes, flush and fetch redirect.
// Rev 1.0
`default_nettype none

module exc_commit_ctrl #(
  parameter logic [31:0] VEC_BEV1 = 32'hBFC00380,
  parameter logic [31:0] VEC_BEV0 = 32'h80000180
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cm_valid,
  output logic        cm_ready,
  input  logic [31:0] cm_pc,
  input  logic        cm_is_branch,
  input  logic        cm_ex_if_adel,
  input  logic        cm_ex_ri,
  input  logic        cm_ex_ov,
  input  logic        cm_ex_sys,
  input  logic        cm_ex_bp,
  input  logic        cm_ex_adel,
  input  logic        cm_ex_ades,
  input  logic [31:0] cm_mem_addr,
  input  logic        cm_eret,
  output logic        cm_kill,
  input  logic        int_req,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic        ex_valid,
  output logic [4:0]  ex_excode,
  output logic        ex_bd,
  output logic [31:0] ex_epc,
  output logic [31:0] ex_badvaddr,
  output logic        ex_eret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state;
  logic        in_ds;
  logic        any_ex;
  logic        take;
  logic        is_exc;
  logic [4:0]  sel_code;
  logic [31:0] sel_badv;
  logic [31:0] vec_pc;
  logic        unused_bits;

  assign unused_bits = ^{cp0_status[31:23], cp0_status[21:0], cp0_cause[31:7], cp0_cause[1:0]};

  assign any_ex   = cm_ex_if_adel | cm_ex_ri | cm_ex_ov | cm_ex_sys |
                    cm_ex_bp | cm_ex_adel | cm_ex_ades;
  assign cm_ready = (state == RUN);
  assign take     = cm_ready & cm_valid & (int_req | any_ex | cm_eret);
  assign cm_kill  = take;
  assign vec_pc   = cp0_status[22] ? VEC_BEV1 : VEC_BEV0;

  // Priority chain; falling through every flag means the take is an eret.
  always_comb begin
    sel_code = 5'd0;
    sel_badv = 32'd0;
    is_exc   = 1'b1;
    if (int_req) begin
      sel_code = 5'd0;
    end else if (cm_ex_if_adel) begin
      sel_code = 5'd4;
      sel_badv = cm_pc;
    end else if (cm_ex_ri) begin
      sel_code = 5'd10;
    end else if (cm_ex_ov) begin
      sel_code = 5'd12;
    end else if (cm_ex_sys) begin
      sel_code = 5'd8;
    end else if (cm_ex_bp) begin
      sel_code = 5'd9;
    end else if (cm_ex_adel) begin
      sel_code = 5'd4;
      sel_badv = cm_mem_addr;
    end else if (cm_ex_ades) begin
      sel_code = 5'd5;
      sel_badv = cm_mem_addr;
    end else begin
      sel_code = cp0_cause[6:2];
      is_exc   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= RUN;
      in_ds          <= 1'b0;
      ex_valid       <= 1'b0;
      ex_excode      <= 5'd0;
      ex_bd          <= 1'b0;
      ex_epc         <= 32'd0;
      ex_badvaddr    <= 32'd0;
      ex_eret        <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (take) begin
            state          <= FLUSH;
            in_ds          <= 1'b0;
            ex_valid       <= 1'b1;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            ex_excode      <= sel_code;
            ex_bd          <= in_ds;
            ex_epc         <= in_ds ? (cm_pc - 32'd4) : cm_pc;
            ex_badvaddr    <= sel_badv;
            ex_eret        <= ~is_exc;
            redirect_pc    <= is_exc ? vec_pc : cp0_epc;
          end else if (cm_valid) begin
            // Bubbles leave in_ds alone so a stalled delay slot is still flagged.
            in_ds <= cm_is_branch;
          end
        end
        FLUSH: begin
          state          <= RUN;
          ex_valid       <= 1'b0;
          flush          <= 1'b0;
          redirect_valid <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exc_commit_ctrl.sv
// tb_exc_commit_ctrl: directed table-driven bench for exc_commit_ctrl.
`default_nettype none

module tb_exc_commit_ctrl;

  logic        clk, resetn;
  logic        cm_valid, cm_ready, cm_is_branch, cm_kill, cm_eret, int_req;
  logic [31:0] cm_pc, cm_mem_addr, cp0_status, cp0_cause, cp0_epc;
  logic        cm_ex_if_adel, cm_ex_ri, cm_ex_ov, cm_ex_sys, cm_ex_bp, cm_ex_adel, cm_ex_ades;
  logic        ex_valid, ex_bd, ex_eret, flush, redirect_valid;
  logic [4:0]  ex_excode;
  logic [31:0] ex_epc, ex_badvaddr, redirect_pc;

  exc_commit_ctrl dut (
    .clk(clk), .resetn(resetn), .cm_valid(cm_valid), .cm_ready(cm_ready),
    .cm_pc(cm_pc), .cm_is_branch(cm_is_branch), .cm_ex_if_adel(cm_ex_if_adel),
    .cm_ex_ri(cm_ex_ri), .cm_ex_ov(cm_ex_ov), .cm_ex_sys(cm_ex_sys), .cm_ex_bp(cm_ex_bp),
    .cm_ex_adel(cm_ex_adel), .cm_ex_ades(cm_ex_ades), .cm_mem_addr(cm_mem_addr),
    .cm_eret(cm_eret), .cm_kill(cm_kill), .int_req(int_req), .cp0_status(cp0_status),
    .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .ex_valid(ex_valid), .ex_excode(ex_excode),
    .ex_bd(ex_bd), .ex_epc(ex_epc), .ex_badvaddr(ex_badvaddr), .ex_eret(ex_eret),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] F_IFA  = 7'b1000000;
  localparam logic [6:0] F_RI   = 7'b0100000;
  localparam logic [6:0] F_OV   = 7'b0010000;
  localparam logic [6:0] F_SYS  = 7'b0001000;
  localparam logic [6:0] F_BP   = 7'b0000100;
  localparam logic [6:0] F_ADEL = 7'b0000010;
  localparam logic [6:0] F_ADES = 7'b0000001;
  localparam logic [31:0] BEV1  = 32'h0040_0000;
  localparam logic [31:0] BEV0  = 32'h0000_0000;

  typedef struct {
    logic        valid, br, eret, irq;
    logic [31:0] pc, mem, st, ca, ep;
    logic [6:0]  fl;
    logic        e_ready, e_kill, e_stb, e_bd, e_eret;
    logic [4:0]  e_code;
    logic [31:0] e_epc, e_bad, e_rpc;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v = '{valid: 1'b0, br: 1'b0, eret: 1'b0, irq: 1'b0, pc: 32'd0, mem: 32'd0, st: BEV1,
          ca: 32'd0, ep: 32'd0, fl: 7'd0, e_ready: 1'b1, e_kill: 1'b0, e_stb: 1'b0,
          e_bd: 1'b0, e_eret: 1'b0, e_code: 5'd0, e_epc: 32'd0, e_bad: 32'd0, e_rpc: 32'd0};
    return v;
  endfunction

  task automatic idle(input logic irq, input logic rdy);
    vec_t v = blank();
    v.irq = irq; v.e_ready = rdy;
    vq.push_back(v);
  endtask

  // Valid instruction with no take condition (retire), or any instruction presented during FLUSH.
  task automatic ret(input logic [31:0] pc, input logic br, input logic [6:0] fl, input logic rdy);
    vec_t v = blank();
    v.valid = 1'b1; v.pc = pc; v.br = br; v.fl = fl; v.e_ready = rdy;
    vq.push_back(v);
  endtask

  task automatic exc(input logic [31:0] pc, input logic [6:0] fl, input logic er, input logic irq,
                     input logic [31:0] mem, input logic [31:0] st, input logic [31:0] ca,
                     input logic [31:0] ep, input logic [4:0] code, input logic bd,
                     input logic [31:0] xepc, input logic [31:0] bad, input logic xer,
                     input logic [31:0] rpc);
    vec_t v = blank();
    v.valid = 1'b1; v.pc = pc; v.fl = fl; v.eret = er; v.irq = irq; v.mem = mem;
    v.st = st; v.ca = ca; v.ep = ep;
    v.e_kill = 1'b1; v.e_stb = 1'b1; v.e_code = code; v.e_bd = bd; v.e_epc = xepc;
    v.e_bad = bad; v.e_eret = xer; v.e_rpc = rpc;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    cm_valid = v.valid; cm_is_branch = v.br; cm_pc = v.pc; cm_eret = v.eret;
    int_req = v.irq; cm_mem_addr = v.mem; cp0_status = v.st; cp0_cause = v.ca; cp0_epc = v.ep;
    {cm_ex_if_adel, cm_ex_ri, cm_ex_ov, cm_ex_sys, cm_ex_bp, cm_ex_adel, cm_ex_ades} = v.fl;
  endtask

  task automatic chk_strobes(input string tag, input logic exp);
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, exp});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, exp});
    chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, exp});
  endtask

  initial begin
    vec_t v;
    resetn = 1'b0;
    drive(blank());
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst.cm_ready", {31'd0, cm_ready}, 32'd1);
    chk("rst.cm_kill", {31'd0, cm_kill}, 32'd0);
    chk_strobes("rst", 1'b0);
    chk("rst.redirect_pc", redirect_pc, 32'd0);
    chk("rst.ex_epc", ex_epc, 32'd0);
    chk("rst.ex_excode", {27'd0, ex_excode}, 32'd0);

    // Overflow, BEV=1
    exc(32'h8000_1000, F_OV, 0, 0, 0, BEV1, 0, 0, 5'd12, 0, 32'h8000_1000, 0, 0, 32'hBFC00380);
    idle(0, 0);
    idle(0, 1);
    // Branch, bubble, delay-slot AdEL
    ret(32'h8000_2000, 1, 0, 1);
    idle(0, 1);
    exc(32'h8000_2004, F_ADEL, 0, 0, 32'h1235, BEV1, 0, 0, 5'd4, 1, 32'h8000_2000, 32'h1235, 0, 32'hBFC00380);
    idle(0, 0);
    // Interrupt pending over bubbles, beats sys and eret, BEV=0
    idle(1, 1); idle(1, 1); idle(1, 1);
    exc(32'h8000_4000, F_SYS, 1, 1, 32'h55, BEV0, 32'h20, 32'h1234, 5'd0, 0, 32'h8000_4000, 0, 0, 32'h80000180);
    idle(0, 0);
    idle(0, 1);
    // eret alone keeps Cause.ExcCode and returns to EPC
    exc(32'h8000_5000, 0, 1, 0, 0, BEV1, 32'h20, 32'h8000_3000, 5'd8, 0, 32'h8000_5000, 0, 1, 32'h8000_3000);
    idle(0, 0);
    idle(0, 1);
    // if_adel beats RI
    exc(32'h0000_0003, F_IFA | F_RI, 0, 0, 32'h99, BEV1, 0, 0, 5'd4, 0, 32'h3, 32'h3, 0, 32'hBFC00380);
    idle(0, 0);
    idle(0, 1);
    // Sys beats Bp; an instruction offered during FLUSH is not taken
    exc(32'h8000_6000, F_SYS | F_BP, 0, 0, 0, BEV1, 0, 0, 5'd8, 0, 32'h8000_6000, 0, 0, 32'hBFC00380);
    ret(32'h8000_6004, 0, F_OV, 0);
    exc(32'h8000_6010, F_ADES, 0, 0, 32'hDEAD_0002, BEV0, 0, 0, 5'd5, 0, 32'h8000_6010, 32'hDEAD_0002, 0, 32'h80000180);
    idle(0, 0);
    exc(32'h8000_6020, F_ADEL | F_ADES, 0, 0, 32'h11, BEV1, 0, 0, 5'd4, 0, 32'h8000_6020, 32'h11, 0, 32'hBFC00380);
    idle(0, 0);
    exc(32'h8000_6030, F_RI | F_OV, 1, 0, 0, BEV1, 32'h7C, 32'h4444, 5'd10, 0, 32'h8000_6030, 0, 0, 32'hBFC00380);
    idle(0, 0);
    exc(32'h8000_6040, F_BP, 0, 0, 0, BEV1, 0, 0, 5'd9, 0, 32'h8000_6040, 0, 0, 32'hBFC00380);
    idle(0, 0);
    // Non-branch retire clears in_ds
    ret(32'h8000_7000, 1, 0, 1);
    ret(32'h8000_7004, 0, 0, 1);
    exc(32'h8000_7008, F_OV, 0, 0, 0, BEV1, 0, 0, 5'd12, 0, 32'h8000_7008, 0, 0, 32'hBFC00380);
    idle(0, 0);
    // EPC wraps when the delay slot is at address 0
    ret(32'hFFFF_FFFC, 1, 0, 1);
    exc(32'h0000_0000, F_BP, 0, 0, 0, BEV1, 0, 0, 5'd9, 1, 32'hFFFF_FFFC, 0, 0, 32'hBFC00380);
    idle(0, 0);
    idle(0, 1);

    foreach (vq[i]) begin
      string tag;
      v = vq[i];
      tag = $sformatf("v%0d", i);
      @(negedge clk);
      drive(v);
      #1;
      chk({tag, ".cm_ready"}, {31'd0, cm_ready}, {31'd0, v.e_ready});
      chk({tag, ".cm_kill"}, {31'd0, cm_kill}, {31'd0, v.e_kill});
      @(posedge clk);
      #1;
      chk_strobes(tag, v.e_stb);
      if (v.e_stb) begin
        chk({tag, ".ex_excode"}, {27'd0, ex_excode}, {27'd0, v.e_code});
        chk({tag, ".ex_bd"}, {31'd0, ex_bd}, {31'd0, v.e_bd});
        chk({tag, ".ex_epc"}, ex_epc, v.e_epc);
        chk({tag, ".ex_badvaddr"}, ex_badvaddr, v.e_bad);
        chk({tag, ".ex_eret"}, {31'd0, ex_eret}, {31'd0, v.e_eret});
        chk({tag, ".redirect_pc"}, redirect_pc, v.e_rpc);
      end
    end

    // Reset clears in_ds: branch retires, reset, then exception is not a delay slot
    @(negedge clk);
    drive(blank());
    cm_valid = 1'b1; cm_pc = 32'h8000_8000; cm_is_branch = 1'b1;
    @(posedge clk);
    #2 resetn = 1'b0;
    drive(blank());
    @(negedge clk);
    resetn = 1'b1;
    cm_valid = 1'b1; cm_pc = 32'h8000_8004; cm_ex_ov = 1'b1;
    @(posedge clk);
    #1;
    chk("ds_rst.ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("ds_rst.ex_bd", {31'd0, ex_bd}, 32'd0);
    chk("ds_rst.ex_epc", ex_epc, 32'h8000_8004);
    // Async reset mid-FLUSH drops strobes immediately
    drive(blank());
    #2 resetn = 1'b0;
    #1;
    chk_strobes("async", 1'b0);
    chk("async.redirect_pc", redirect_pc, 32'd0);
    chk("async.ex_epc", ex_epc, 32'd0);
    chk("async.cm_ready", {31'd0, cm_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("async_rel.cm_ready", {31'd0, cm_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk_strobes("async_rel", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
